// File: rtl/axi_vga_fetch_pkg.sv
// Shared types and helpers for the VGA framebuffer AR fetch scheduler.
package axi_vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int Page4k = 4096;

    // Beats that still fit before the next 4 KiB page boundary.
    function automatic logic [12:0] beats_to_page(input logic [11:0] page_off,
                                                  input int beat_bytes);
        int bytes_left;
        bytes_left = Page4k - int'(page_off);
        return 13'(bytes_left / beat_bytes);
    endfunction

endpackage

// File: rtl/axi_vga_fetch_credit.sv
// Outstanding-burst and in-flight-beat bookkeeping plus the AR grant test.
module axi_vga_fetch_credit #(
    parameter int MaxOutstanding = 4,
    parameter int FifoCntWidth   = 10
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  ar_hs,
    input  logic [8:0]                            hs_beats,
    input  logic                                  r_beat,
    input  logic                                  r_last,
    input  logic [FifoCntWidth:0]                 fifo_free,
    input  logic [8:0]                            req_beats,
    output logic                                  grant,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding
);

    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam int CntW = FifoCntWidth + 1;

    logic [CntW-1:0] inflight_beats, inflight_d;
    logic [OutW-1:0] outstanding_d;
    logic [CntW:0]   need;

    // Handshake and R beat may land together; both deltas are applied.
    always_comb begin
        inflight_d    = inflight_beats;
        outstanding_d = outstanding;
        if (ar_hs) begin
            inflight_d    = inflight_d + CntW'(hs_beats);
            outstanding_d = outstanding_d + OutW'(1);
        end
        if (r_beat) inflight_d = inflight_d - CntW'(1);
        if (r_beat && r_last) outstanding_d = outstanding_d - OutW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_beats <= '0;
            outstanding    <= '0;
        end else begin
            inflight_beats <= inflight_d;
            outstanding    <= outstanding_d;
        end
    end

    assign need  = {1'b0, inflight_beats} + (CntW+1)'(req_beats);
    assign grant = (outstanding < OutW'(MaxOutstanding)) && ({1'b0, fifo_free} >= need);

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_beat && !ar_hs && inflight_beats == '0));
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_beat && r_last && !ar_hs && outstanding == '0));

endmodule

// File: rtl/axi_vga_fetch_ctrl.sv
// VGA framebuffer AR burst scheduler; credit-limited so the pixel FIFO never overflows.
// Optional AXI_VGA_FETCH_ERR_EN adds a sticky R-error flag err_o that halts issuing.
module axi_vga_fetch_ctrl
    import axi_vga_fetch_pkg::*;
#(
    parameter int AddrWidth      = 64,
    parameter int BeatBytes      = 8,
    parameter int MaxOutstanding = 4,
    parameter int FifoCntWidth   = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  start_sync_i,
    input  logic [AddrWidth-1:0]  fb_base_i,
    input  logic [31:0]           frame_bytes_i,
    input  logic [7:0]            burst_len_i,
    input  logic [FifoCntWidth:0] fifo_free_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [AddrWidth-1:0]  ar_addr_o,
    output logic [7:0]            ar_len_o,
    input  logic                  r_valid_i,
    input  logic                  r_ready_i,
    input  logic                  r_last_i,
    input  logic [1:0]            r_resp_i,
`ifdef AXI_VGA_FETCH_ERR_EN
    output logic                  err_o,
`endif
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int BeatShift = $clog2(BeatBytes);
    localparam int OutW      = $clog2(MaxOutstanding + 1);

    fetch_state_t          state_q, state_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [31:0]           remain_q, remain_beats, hs_bytes;
    logic [12:0]           page_beats;
    logic [8:0]            beats, hs_beats;
    logic                  restart_pend_q, ovr_pend_q, err_q;
    logic                  ar_hs, r_beat, start_acc, do_restart, issue_en, raise, overrun_d, grant;
    logic [OutW-1:0]       outstanding;

    assign ar_hs      = ar_valid_o & ar_ready_i;
    assign r_beat     = r_valid_i & r_ready_i;
    assign hs_beats   = {1'b0, ar_len_o} + 9'd1;
    assign hs_bytes   = 32'(hs_beats) << BeatShift;
    assign start_acc  = start_sync_i & enable_i;
    // A restart waits until any presented AR has been accepted.
    assign do_restart = (state_q != IDLE) & enable_i & (start_sync_i | restart_pend_q)
                      & (~ar_valid_o | ar_ready_i);
    assign issue_en   = enable_i & ~err_q;
    assign busy_o     = (state_q != IDLE);

`ifdef AXI_VGA_FETCH_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                               err_q <= 1'b0;
        else if (r_beat && r_resp_i != 2'b00)    err_q <= 1'b1;
        else if (start_acc)                      err_q <= 1'b0;
    end
    assign err_o = err_q;
`else
    logic unused_resp;
    assign err_q       = 1'b0;
    assign unused_resp = ^r_resp_i;
`endif

    assign remain_beats = remain_q >> BeatShift;
    assign page_beats   = beats_to_page(addr_q[11:0], BeatBytes);

    always_comb begin
        beats = {1'b0, burst_len_i} + 9'd1;
        if (remain_beats < 32'(beats)) beats = remain_beats[8:0];
        if (page_beats < 13'(beats))   beats = page_beats[8:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_acc && frame_bytes_i != '0) state_d = ISSUE;
            ISSUE: begin
                if (do_restart)
                    state_d = (frame_bytes_i != '0) ? ISSUE : DRAIN;
                else if (!issue_en || (ar_hs && remain_q == hs_bytes))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (do_restart)
                    state_d = (frame_bytes_i != '0) ? ISSUE : DRAIN;
                else if (outstanding == '0 && !ar_valid_o)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        raise     = (state_q == ISSUE) && issue_en && !ar_valid_o && !start_sync_i
                  && !restart_pend_q && (remain_q != '0) && grant;
        overrun_d = do_restart && (ovr_pend_q || (start_sync_i && state_q == ISSUE));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ar_valid_o     <= 1'b0;
            ar_addr_o      <= '0;
            ar_len_o       <= '0;
            overrun_o      <= 1'b0;
            addr_q         <= '0;
            remain_q       <= '0;
            restart_pend_q <= 1'b0;
            ovr_pend_q     <= 1'b0;
        end else begin
            overrun_o <= overrun_d;
            if (raise) begin
                ar_valid_o <= 1'b1;
                ar_addr_o  <= addr_q;
                ar_len_o   <= 8'(beats - 9'd1);
            end else if (ar_hs) begin
                ar_valid_o <= 1'b0;
            end
            if ((state_q == IDLE && start_acc) || do_restart) begin
                addr_q   <= fb_base_i;
                remain_q <= frame_bytes_i;
            end else if (ar_hs) begin
                addr_q   <= addr_q + AddrWidth'(hs_bytes);
                remain_q <= remain_q - hs_bytes;
            end
            if (do_restart || !enable_i) begin
                restart_pend_q <= 1'b0;
                ovr_pend_q     <= 1'b0;
            end else if (state_q != IDLE && start_sync_i && ar_valid_o && !ar_ready_i) begin
                restart_pend_q <= 1'b1;
                if (state_q == ISSUE) ovr_pend_q <= 1'b1;
            end
        end
    end

    axi_vga_fetch_credit #(
        .MaxOutstanding(MaxOutstanding),
        .FifoCntWidth  (FifoCntWidth)
    ) u_credit (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_hs      (ar_hs),
        .hs_beats   (hs_beats),
        .r_beat     (r_beat),
        .r_last     (r_last_i),
        .fifo_free  (fifo_free_i),
        .req_beats  (beats),
        .grant      (grant),
        .outstanding(outstanding)
    );

endmodule

// File: tb/tb_axi_vga_fetch_ctrl.sv
// Directed bench for axi_vga_fetch_ctrl: frame vector table plus multi-cycle corner sequences.
module tb_axi_vga_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, enable_i, start_sync_i;
    logic [63:0] fb_base_i;
    logic [31:0] frame_bytes_i;
    logic [7:0]  burst_len_i;
    logic [10:0] fifo_free_i;
    logic        ar_valid_o, ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic        r_valid_i, r_ready_i, r_last_i;
    logic [1:0]  r_resp_i;
    logic        busy_o, overrun_o;
`ifdef AXI_VGA_FETCH_ERR_EN
    logic        err_o;
`endif

    always #5 clk = ~clk;

    axi_vga_fetch_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .start_sync_i(start_sync_i),
        .fb_base_i(fb_base_i), .frame_bytes_i(frame_bytes_i), .burst_len_i(burst_len_i),
        .fifo_free_i(fifo_free_i), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .r_valid_i(r_valid_i),
        .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_resp_i(r_resp_i),
`ifdef AXI_VGA_FETCH_ERR_EN
        .err_o(err_o),
`endif
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    typedef struct {
        logic [63:0] base;
        logic [31:0] frame;
        logic [7:0]  bl;
        int          n;
        logic [63:0] a0;
        logic [7:0]  l0;
        logic [63:0] al;
        logic [7:0]  ll;
    } vec_t;

    vec_t        vecs[5];
    logic [63:0] alog[$];
    logic [7:0]  llog[$];
    int          rq[$];
    int          checks = 0, errors = 0;
    int          ovr_cnt = 0, beat_no = 0, err_beat = -1;
    logic        r_stall = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // AR handshake monitor: samples just before the edge that completes it.
    always begin
        @(negedge clk); #2;
        if (!rst_i && ar_valid_o && ar_ready_i) begin
            alog.push_back(ar_addr_o);
            llog.push_back(ar_len_o);
            rq.push_back(int'(ar_len_o) + 1);
        end
        if (!rst_i && overrun_o) ovr_cnt++;
    end

    // R responder: streams the beats of accepted bursts in order.
    initial begin
        r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (rst_i) begin
                rq.delete(); beat_no = 0;
                r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
            end else begin
                if (r_valid_i && r_ready_i) begin
                    rq[0] = rq[0] - 1;
                    if (rq[0] == 0) void'(rq.pop_front());
                    beat_no++;
                end
                r_resp_i = 2'b00;
                if (!r_stall && rq.size() > 0) begin
                    r_valid_i = 1'b1;
                    r_last_i  = (rq[0] == 1);
                    if (beat_no == err_beat) r_resp_i = 2'b10;
                end else begin
                    r_valid_i = 1'b0; r_last_i = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; start_sync_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        alog.delete(); llog.delete(); ovr_cnt = 0;
    endtask

    task automatic release_reset();
        rst_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_sync_i = 1'b1;
        @(posedge clk); #1 start_sync_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy_o && n < budget) begin @(negedge clk); n++; end
        chk(nm, 64'(busy_o), 64'd0);
    endtask

    task automatic wait_log(input int cnt, input int budget, input string nm);
        int n = 0;
        while (alog.size() < cnt && n < budget) begin @(negedge clk); n++; end
        chk(nm, 64'(alog.size() >= cnt), 64'd1);
    endtask

    task automatic setup(input logic [63:0] b, input logic [31:0] f, input logic [7:0] bl,
                         input logic [10:0] ff);
        fb_base_i = b; frame_bytes_i = f; burst_len_i = bl; fifo_free_i = ff;
        enable_i = 1'b1; ar_ready_i = 1'b1; r_stall = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [63:0] sum;
        int          bad, snap, n;

        vecs[0] = '{64'h8000_0000, 32'd4096, 8'd15,  32, 64'h8000_0000, 8'd15, 64'h8000_0F80, 8'd15};
        vecs[1] = '{64'h8000_0FC0, 32'd256,  8'd15,  3,  64'h8000_0FC0, 8'd7,  64'h8000_1080, 8'd7};
        vecs[2] = '{64'h0000_1000, 32'd40,   8'd15,  1,  64'h0000_1000, 8'd4,  64'h0000_1000, 8'd4};
        vecs[3] = '{64'h0000_2000, 32'd24,   8'd0,   3,  64'h0000_2000, 8'd0,  64'h0000_2010, 8'd0};
        vecs[4] = '{64'h0000_3F00, 32'd512,  8'd255, 2,  64'h0000_3F00, 8'd31, 64'h0000_4000, 8'd31};

        rst_i = 1'b1; enable_i = 1'b0; start_sync_i = 1'b0; fb_base_i = '0;
        frame_bytes_i = '0; burst_len_i = '0; fifo_free_i = '0; ar_ready_i = 1'b0;
        r_ready_i = 1'b1;

        do_reset();
        chk("rst_ar_valid", 64'(ar_valid_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_overrun", 64'(overrun_o), 0);
        chk("rst_ar_addr", ar_addr_o, 0);
        chk("rst_ar_len", 64'(ar_len_o), 0);
        chk("rst_outstanding", 64'(dut.u_credit.outstanding), 0);
        chk("rst_inflight", 64'(dut.u_credit.inflight_beats), 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            setup(vecs[i].base, vecs[i].frame, vecs[i].bl, 11'd512);
            release_reset();
            pulse_start();
            wait_idle(4000, $sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_nburst", i), 64'(alog.size()), 64'(vecs[i].n));
            chk($sformatf("v%0d_addr0", i), alog[0], vecs[i].a0);
            chk($sformatf("v%0d_len0", i), 64'(llog[0]), 64'(vecs[i].l0));
            chk($sformatf("v%0d_addrlast", i), alog[alog.size()-1], vecs[i].al);
            chk($sformatf("v%0d_lenlast", i), 64'(llog[llog.size()-1]), 64'(vecs[i].ll));
            chk($sformatf("v%0d_r_drained", i), 64'(rq.size()), 0);
            chk($sformatf("v%0d_no_overrun", i), 64'(ovr_cnt), 0);
            sum = 0; bad = 0;
            for (int j = 0; j < alog.size(); j++) begin
                sum += (64'(llog[j]) + 1) * 8;
                if (j > 0 && alog[j] != alog[j-1] + (64'(llog[j-1]) + 1) * 8) bad++;
                if ((alog[j] & 64'hFFF) + (64'(llog[j]) + 1) * 8 > 64'd4096) bad++;
            end
            chk($sformatf("v%0d_bytes", i), sum, 64'(vecs[i].frame));
            chk($sformatf("v%0d_contig_page", i), 64'(bad), 0);
        end

        // Credit limit: 20 free entries admit one 16-beat burst, 32 admit two.
        do_reset();
        setup(64'h0, 32'd4096, 8'd15, 11'd20);
        r_stall = 1'b1;
        release_reset();
        pulse_start();
        repeat (20) @(negedge clk);
        chk("credit_one_ar", 64'(alog.size()), 1);
        chk("credit_no_valid", 64'(ar_valid_o), 0);
        @(posedge clk); #1 fifo_free_i = 11'd32;
        repeat (12) @(negedge clk);
        chk("credit_two_ar", 64'(alog.size()), 2);
        chk("credit_inflight", 64'(dut.u_credit.inflight_beats), 32);
        @(posedge clk); #1 enable_i = 1'b0; r_stall = 1'b0;
        wait_idle(500, "credit_drain_idle");
        chk("credit_drain_count", 64'(alog.size()), 2);

        // Restart while an AR is stalled: AR held, then next AR at base, one overrun.
        do_reset();
        setup(64'h8000_0000, 32'd4096, 8'd15, 11'd512);
        release_reset();
        pulse_start();
        n = 0;
        while (alog.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
        ar_ready_i = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!ar_valid_o && n < 50);
        chk("rs_pending", 64'(ar_valid_o), 1);
        chk("rs_pending_addr", ar_addr_o, 64'h8000_0100);
        pulse_start();
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!ar_valid_o || ar_addr_o != 64'h8000_0100 || ar_len_o != 8'd15) bad++;
        end
        chk("rs_hold_stable", 64'(bad), 0);
        @(posedge clk); #1 ar_ready_i = 1'b1;
        wait_log(4, 200, "rs_next_ar");
        chk("rs_third_addr", alog[2], 64'h8000_0100);
        chk("rs_restart_addr", alog[3], 64'h8000_0000);
        chk("rs_restart_len", 64'(llog[3]), 15);
        wait_idle(4000, "rs_idle");
        chk("rs_overrun_once", 64'(ovr_cnt), 1);
        chk("rs_total_bursts", 64'(alog.size()), 35);

        // Same-cycle AR handshake and R last: net counter update.
        do_reset();
        setup(64'h0, 32'd4096, 8'd15, 11'd512);
        release_reset();
        pulse_start();
        n = 0;
        while (alog.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
        ar_ready_i = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(r_valid_i && r_last_i && ar_valid_o) && n < 100);
        chk("sc_aligned", 64'(r_valid_i && r_last_i && ar_valid_o), 1);
        chk("sc_old_outstanding", 64'(dut.u_credit.outstanding), 1);
        chk("sc_old_inflight", 64'(dut.u_credit.inflight_beats), 1);
        ar_ready_i = 1'b1;
        @(negedge clk);
        chk("sc_outstanding", 64'(dut.u_credit.outstanding), 1);
        chk("sc_inflight", 64'(dut.u_credit.inflight_beats), 16);
        @(posedge clk); #1 enable_i = 1'b0;
        wait_idle(1000, "sc_idle");

`ifdef AXI_VGA_FETCH_ERR_EN
        // Error response on the third beat halts the frame until the next start.
        do_reset();
        setup(64'h8000_0000, 32'd4096, 8'd15, 11'd512);
        err_beat = 2;
        release_reset();
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!(r_valid_i && r_resp_i != 2'b00) && n < 200);
        chk("err_beat_seen", 64'(r_valid_i && r_resp_i != 2'b00), 1);
        err_beat = -1;
        @(negedge clk);
        chk("err_set", 64'(err_o), 1);
        repeat (3) @(negedge clk);
        snap = alog.size();
        wait_idle(1000, "err_idle");
        chk("err_no_new_ar", 64'(alog.size()), 64'(snap));
        chk("err_sticky", 64'(err_o), 1);
        pulse_start();
        @(negedge clk);
        chk("err_cleared", 64'(err_o), 0);
        wait_log(snap + 1, 100, "err_restart_ar");
        chk("err_restart_addr", alog[snap], 64'h8000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_vga_fetch_ctrl.md
Name: axi_vga_fetch_ctrl

Overview:
- Read-request scheduler for the VGA framebuffer path.
- Issues AXI AR bursts that stream one frame from memory into the pixel FIFO feeding the timing FSM.
- Frame restart is triggered by the timing FSM's vertical-sync-start pulse.
- Uses a credit scheme (FIFO free space minus beats in flight) so the FIFO can never overflow.

Parameters:
- AddrWidth, 64: AXI address width.
- BeatBytes, 8: bytes per R beat; power of two.
- MaxOutstanding, 4: maximum AR bursts in flight.
- FifoCntWidth, 10: width of the FIFO free-space count (count port is FifoCntWidth+1 bits).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- enable_i  in  1  control.enable AND'd with the external enable.
- start_sync_i  in  1  one-cycle pulse at vertical SYNC entry.
- fb_base_i  in  AddrWidth  frame base address, BeatBytes-aligned.
- frame_bytes_i  in  32  frame size in bytes, multiple of BeatBytes.
- burst_len_i  in  8  nominal burst length, AXI encoding (beats-1).
- fifo_free_i  in  FifoCntWidth+1  free FIFO entries.
- ar_valid_o  out  1  AR valid.
- ar_ready_i  in  1  AR ready.
- ar_addr_o  out  AddrWidth  AR address.
- ar_len_o  out  8  AR length.
- r_valid_i  in  1  R valid.
- r_ready_i  in  1  R ready (FIFO push side).
- r_last_i  in  1  R last.
- r_resp_i  in  2  R response.
- busy_o  out  1  high whenever state is not IDLE.
- overrun_o  out  1  one-cycle pulse: new frame started before the previous frame's requests were all issued.

Behaviour:
- Reset: all outputs 0; state IDLE; address, remaining count, inflight_beats and outstanding all 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on start_sync_i & enable_i. Same cycle: addr_q <= fb_base_i, remain_q <= frame_bytes_i. frame_bytes_i = 0: stay IDLE.
- Burst length per request: beats = min(burst_len_i+1, remain_q/BeatBytes, beats left to the next 4 KiB boundary). ar_len_o = beats-1. Bursts never cross 4 KiB.
- ISSUE asserts ar_valid_o when both hold:
  - outstanding < MaxOutstanding;
  - fifo_free_i >= inflight_beats + beats.
- Latency: ar_valid_o rises one cycle after the condition is met (registered outputs).
- While ar_valid_o is high, ar_addr_o/ar_len_o are stable and ar_valid_o does not drop until ar_ready_i.
- On AR handshake:
  - addr_q += beats*BeatBytes; remain_q -= beats*BeatBytes;
  - outstanding +1; inflight_beats += beats.
- On each R beat (r_valid_i & r_ready_i): inflight_beats -1. On R beat with r_last_i: outstanding -1.
- Simultaneous AR handshake and R beat/last: both updates apply in the same cycle (net arithmetic, no lost count).
- ISSUE -> DRAIN when remain_q reaches 0 after a handshake.
- DRAIN -> IDLE when outstanding = 0 and no AR is pending.
- start_sync_i in ISSUE or DRAIN:
  - a pending AR completes its handshake first;
  - then re-latch base and size and go to ISSUE;
  - pulse overrun_o only if the pulse arrived in ISSUE;
  - in-flight R beats still decrement the counters.
- enable_i low: no new AR is raised; a pending AR completes; go to DRAIN, then IDLE. start_sync_i is ignored while disabled.
- Counter widths: outstanding is clog2(MaxOutstanding+1) bits; inflight_beats is FifoCntWidth+1 bits. Underflow is impossible by construction; assertion-checked in simulation.

Optional Feature:
- Macro: AXI_VGA_FETCH_ERR_EN.
- Defined: adds output err_o (1 bit).
  - Sticky-set on any R beat with r_resp_i != 2'b00.
  - Cleared on rst_i or on the next accepted start_sync_i.
  - While err_o is high, ISSUE raises no new AR; the frame drains and stops.
- Undefined: no err_o port; r_resp_i is ignored.

Decomposition:
- Shared package axi_vga_fetch_pkg:
  - state enum fetch_state_t;
  - localparam Page4k = 4096;
  - helper function for beats to the 4 KiB boundary.
- Sub-module axi_vga_fetch_credit: outstanding/inflight_beats counters and the grant condition.

Test Plan:
- Base 0x8000_0000, frame_bytes 4096, burst_len 15, fifo_free 512, ar_ready=1 -> 32 bursts, addresses step by 0x80, all ar_len=15; busy_o drops after the last r_last.
- Base 0x8000_0FC0, frame 256, burst_len 15 -> first AR len=7 (64 B to page end), then len=15 at 0x8000_1000, then len=7.
- fifo_free 20, burst_len 15, R stalled -> exactly one AR issued; second AR raised only after the free count is raised to 32.
- start_sync_i pulsed mid-frame while ar_valid_o=1 and ar_ready_i=0 -> AR held stable; after ready, the next AR goes to fb_base; overrun_o pulses once.
- Same-cycle AR handshake and R last beat -> outstanding unchanged, inflight_beats = old + 16 - 1.
- Under AXI_VGA_FETCH_ERR_EN: r_resp=2'b10 on beat 3 -> err_o=1 next cycle, no further AR; next start_sync_i clears err_o and restarts the frame.
